buffer_sched: RTL

- Sequencing controller for the 64-byte shared USB data buffer.
- Decides which side owns the buffer at any time: the RX packet engine, the TX packet engine, or the host-side register interface.
- Converts requests from the owning side into single-cycle buffer strobes (store_RX_packet_data, get_RX_data, store_TX_data, get_TX_packet_data, clear, flush).
- Blocks conflicting access with an error/overflow indication; keeps its own byte count for full/empty decisions.

---
 rtl/usb_buf_pkg.sv | 18 +
 rtl/buffer_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_buf_pkg.sv
// Shared definitions for the 64-byte USB data buffer and its sequencing
// controller: buffer geometry and the controller state encoding.
package usb_buf_pkg;

    localparam int BUF_DEPTH = 64;  // buffer capacity in bytes
    localparam int BUF_CNT_W = 7;   // byte count width, holds 0..BUF_DEPTH

    // Encoding is visible on buf_state, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOST_FILL = 3'd1,
        ST_TX_SEND   = 3'd2,
        ST_RX_FILL   = 3'd3,
        ST_RX_HOLD   = 3'd4,
        ST_CLR       = 3'd5
    } buf_state_t;

endpackage

// File: rtl/buffer_sched.sv
// buffer_sched: decides which side (RX engine, TX engine, host) owns the
// shared USB data buffer and turns the owner's requests into single-cycle
// buffer strobes. A shadow byte count drives full/empty decisions.
// Optional feature: define BUF_SCHED_RX_TIMEOUT_EN to abort an RX packet
// whose bytes stop arriving for TIMEOUT_CYCLES cycles.
module buffer_sched
    import usb_buf_pkg::*;
#(
    parameter int DEPTH          = BUF_DEPTH,
    parameter int CNT_W          = BUF_CNT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_wr_req,
    input  logic             host_rd_req,
    input  logic             host_tx_go,
    input  logic             host_clear,
    input  logic             rx_start,
    input  logic             rx_byte_valid,
    input  logic             rx_done,
    input  logic             rx_abort,
    input  logic             tx_byte_req,
    input  logic             tx_done,
    input  logic             clear_done,
    output logic             store_TX_data,
    output logic             get_RX_data,
    output logic             store_RX_packet_data,
    output logic             get_TX_packet_data,
    output logic             clear,
    output logic             flush,
    output logic             host_wr_ack,
    output logic             host_rd_ack,
    output logic             tx_byte_ack,
    output logic             host_err,
    output logic             rx_overflow,
    output logic [2:0]       buf_state,
    output logic [CNT_W-1:0] buf_count
);

    buf_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Remembers which strobe CLR must repeat: 1 = flush, 0 = clear.
    logic             flush_kind_q, flush_kind_d;

    logic can_store;
    logic can_get;
    logic host_any;
    logic timeout;

    assign can_store = (count_q < CNT_W'(DEPTH));
    assign can_get   = (count_q != '0);
    assign host_any  = host_wr_req | host_rd_req | host_tx_go | host_clear;

`ifdef BUF_SCHED_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // A quiet RX_FILL cycle (no byte, no end of packet) that completes the
    // TIMEOUT_CYCLES-th idle cycle in a row aborts the packet.
    assign timeout = (state_q == ST_RX_FILL) && !rx_byte_valid && !rx_done &&
                     !rx_abort && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: counts only while staying in RX_FILL without a byte.
    always_comb begin
        idle_d = '0;
        if ((state_q == ST_RX_FILL) && (state_d == ST_RX_FILL) && !rx_byte_valid)
            idle_d = idle_q + IDLE_W'(1);
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Ownership FSM: strobes, acks and refusals for the current cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d              = state_q;
        flush_kind_d         = flush_kind_q;
        store_TX_data        = 1'b0;
        get_RX_data          = 1'b0;
        store_RX_packet_data = 1'b0;
        get_TX_packet_data   = 1'b0;
        clear                = 1'b0;
        flush                = 1'b0;
        host_wr_ack          = 1'b0;
        host_rd_ack          = 1'b0;
        tx_byte_ack          = 1'b0;
        host_err             = 1'b0;
        rx_overflow          = 1'b0;

        // Strobes are gated by reset so a mid-operation reset never
        // pulses the buffer.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    host_err = host_rd_req | host_tx_go;
                    if (rx_start) begin
                        state_d = ST_RX_FILL;
                    end else if (host_clear) begin
                        clear        = 1'b1;
                        flush_kind_d = 1'b0;
                        state_d      = ST_CLR;
                    end else if (host_wr_req) begin
                        if (can_store) begin
                            store_TX_data = 1'b1;
                            host_wr_ack   = 1'b1;
                            state_d       = ST_HOST_FILL;
                        end else begin
                            host_err = 1'b1;
                        end
                    end
                end

                ST_HOST_FILL: begin
                    rx_overflow = rx_start;
                    host_err    = host_rd_req;
                    if (host_clear) begin
                        clear        = 1'b1;
                        flush_kind_d = 1'b0;
                        state_d      = ST_CLR;
                    end else if (host_tx_go) begin
                        state_d = ST_TX_SEND;
                    end else if (host_wr_req) begin
                        if (can_store) begin
                            store_TX_data = 1'b1;
                            host_wr_ack   = 1'b1;
                        end else begin
                            host_err = 1'b1;
                        end
                    end
                end

                ST_TX_SEND: begin
                    host_err    = host_any;
                    rx_overflow = rx_start;
                    if (tx_done) begin
                        flush        = 1'b1;
                        flush_kind_d = 1'b1;
                        state_d      = ST_CLR;
                    end else if (tx_byte_req && can_get) begin
                        get_TX_packet_data = 1'b1;
                        tx_byte_ack        = 1'b1;
                    end
                end

                ST_RX_FILL: begin
                    host_err = host_any;
                    if (rx_abort) begin
                        flush        = 1'b1;
                        flush_kind_d = 1'b1;
                        state_d      = ST_CLR;
                    end else begin
                        if (rx_byte_valid) begin
                            if (can_store) store_RX_packet_data = 1'b1;
                            else           rx_overflow          = 1'b1;
                        end
                        // A byte arriving with rx_done counts toward the hold.
                        if (rx_done) begin
                            state_d = (can_get || store_RX_packet_data) ? ST_RX_HOLD : ST_IDLE;
                        end else if (timeout) begin
                            flush        = 1'b1;
                            flush_kind_d = 1'b1;
                            rx_overflow  = 1'b1;
                            state_d      = ST_CLR;
                        end
                    end
                end

                ST_RX_HOLD: begin
                    rx_overflow = rx_start;
                    host_err    = host_wr_req | host_tx_go;
                    if (host_clear) begin
                        clear        = 1'b1;
                        flush_kind_d = 1'b0;
                        state_d      = ST_CLR;
                    end else if (host_rd_req) begin
                        if (can_get) begin
                            get_RX_data = 1'b1;
                            host_rd_ack = 1'b1;
                            if (count_q == CNT_W'(1)) state_d = ST_IDLE;
                        end else begin
                            host_err = 1'b1;
                        end
                    end
                end

                ST_CLR: begin
                    host_err    = host_any;
                    rx_overflow = rx_start;
                    if (clear_done) begin
                        state_d = ST_IDLE;
                    end else if (flush_kind_q) begin
                        flush = 1'b1;
                    end else begin
                        clear = 1'b1;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shadow byte count: clear/flush wins, otherwise one store or one get.
    always_comb begin
        count_d = count_q;
        if (clear || flush)
            count_d = '0;
        else if (store_TX_data || store_RX_packet_data)
            count_d = count_q + CNT_W'(1);
        else if (get_RX_data || get_TX_packet_data)
            count_d = count_q - CNT_W'(1);
    end

    // State, count and pending-strobe kind registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            flush_kind_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            flush_kind_q <= flush_kind_d;
        end
    end

    assign buf_state = state_q;
    assign buf_count = count_q;

endmodule
